bsg_nonsynth_axi_burst_mem: RTL and testbench
=============================================

// Module: bsg_nonsynth_axi_burst_mem
// PURPOSE
//  Non-synthesizable AXI4 slave memory model for cache-to-AXI and DMA benches. Supersedes the
//  INCR-only model: adds FIXED/INCR/WRAP bursts, byte strobes, programmable read latency,
//  SLVERR for out-of-range or malformed bursts. Independent read and write channels run
//  concurrently, one outstanding transaction per channel.
// PARAMETERS
//  axi_id_width_p    6     AWID/ARID/BID/RID width
//  axi_addr_width_p  32    byte address width
//  axi_data_width_p  64    beat width; multiple of 8; bytes_lp = axi_data_width_p/8
//  axi_len_width_p   8     AxLEN width (beats = len+1)
//  mem_els_p         1024  memory depth in beats
//  init_data_p       '0    value loaded into every word while reset_i is high
//  read_latency_p    0     idle cycles inserted between AR handshake and first R beat
// PORTS
//  clk_i      in  1             clock
//  reset_i    in  1             synchronous, active-high reset
//  axi_aw{id,addr,len,burst}_i in id/addr/len/2   write address channel payload
//  axi_awvalid_i in 1 / axi_awready_o out 1        write address handshake
//  axi_wdata_i in data / axi_wstrb_i in bytes_lp / axi_wlast_i in 1   write data payload
//  axi_wvalid_i in 1 / axi_wready_o out 1          write data handshake
//  axi_bid_o out id / axi_bresp_o out 2 / axi_bvalid_o out 1 / axi_bready_i in 1   write response
//  axi_ar{id,addr,len,burst}_i in id/addr/len/2   read address channel payload
//  axi_arvalid_i in 1 / axi_arready_o out 1        read address handshake
//  axi_rid_o out id / axi_rdata_o out data / axi_rresp_o out 2 / axi_rlast_o out 1   read data
//  axi_rvalid_o out 1 / axi_rready_i in 1          read data handshake
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, ids/resp/rdata/rlast 0, both FSMs idle, memory := init_data_p.
//  Reset mid-burst aborts both channels; outputs drop the cycle after reset_i rises (sync).
//  Index = addr[axi_addr_width_p-1:lg(bytes_lp)]; low byte bits ignored. idx >= mem_els_p is
//  out of range: writes dropped, reads return 0, response SLVERR (2'b10), else OKAY (2'b00).
//  Next index: FIXED(00) idx; INCR(01) idx+1; WRAP(10) (idx&~len)|((idx+1)&len).
//  WRAP with len+1 not in {2,4,8,16}, or burst 11: processed as INCR, response SLVERR.
//  Write FSM: W_IDLE(awready=1) --aw hs, latch id/idx/len/burst, clear err--> W_DATA(wready=1);
//   each w hs writes bytes where wstrb=1, beat_cnt++, idx advances; wlast must equal
//   (beat_cnt==len) else err set; after beat len --> W_RESP(bvalid=1, bid latched,
//   bresp=err?SLVERR:OKAY) --b hs--> W_IDLE. wready first high cycle after AW hs.
//  Read FSM: R_IDLE(arready=1) --ar hs--> R_WAIT (read_latency_p cycles; skipped when 0)
//   --> R_DATA(rvalid=1, rdata=mem[idx] comb., rlast=(beat_cnt==len), rid latched);
//   rvalid first at AR hs cycle +1+read_latency_p; rready=0 holds all R outputs stable;
//   after r hs on last beat --> R_IDLE (arready next cycle, no back-to-back bypass).
//  Same-word read beat and write beat in one cycle: read returns pre-write data.
//  Beat counters axi_len_width_p bits; len=255 completes without overflow.
//  awready/arready low outside idle; AW/W ordering: W beats before AW hs are not accepted.
// STRUCTURE
//  bsg_axi_pkg: burst enum (e_axi_burst_fixed/incr/wrap), resp codes e_axi_resp_okay/slverr.
//  Local state enums for write/read FSMs. Sub-module bsg_axi_burst_addr_gen (next idx +
//  illegal-wrap flag from idx/len/burst), instantiated once per channel.
// TESTING (64b data, addr 0x20 = idx 4)
//  INCR AW len=3 @0x20, W 0x11,0x22,0x33,0x44 strb 0xFF -> bresp 00; INCR AR -> same 4, rlast on 4th.
//  WRAP AR len=3 @idx 6 -> beats from idx 6,7,4,5; WRAP len=2 -> INCR order, rresp 10.
//  Word=all-1s, W strb 0x0F data 0 -> readback 0xFFFFFFFF_00000000.
//  read_latency_p=3: rvalid exactly 4 cycles after AR hs; rready low 2 cycles -> rdata/rlast stable.
//  AW @idx mem_els_p, len=1 -> bresp 10, memory unchanged; AR there -> rdata 0, rresp 10.
//  Reset mid W burst -> wready/bvalid 0 next cycle, awready 1 after release, memory=init_data_p.

Source files
------------

// File: rtl/bsg_axi_pkg.sv
// bsg_axi_pkg: AXI4 burst and response encodings shared by the burst memory model.
package bsg_axi_pkg;
   typedef enum logic [1:0] {
      e_axi_burst_fixed = 2'b00,
      e_axi_burst_incr  = 2'b01,
      e_axi_burst_wrap  = 2'b10
   } bsg_axi_burst_e;
   typedef enum logic [1:0] {
      e_axi_resp_okay   = 2'b00,
      e_axi_resp_slverr = 2'b10
   } bsg_axi_resp_e;
   function automatic bsg_axi_resp_e axi_resp(input logic err);
      return err ? e_axi_resp_slverr : e_axi_resp_okay;
   endfunction
endpackage

// File: rtl/bsg_axi_burst_addr_gen.sv
// bsg_axi_burst_addr_gen: next beat index for FIXED/INCR/WRAP bursts plus malformed-burst flag.
module bsg_axi_burst_addr_gen
   import bsg_axi_pkg::*;
#(
   parameter int idx_width_p = 29,
   parameter int len_width_p = 8
) (
   input  logic [idx_width_p-1:0] idx_i,
   input  logic [len_width_p-1:0] len_i,
   input  logic [1:0]             burst_i,
   output logic [idx_width_p-1:0] next_idx_o,
   output logic                   illegal_o
);
   logic [idx_width_p-1:0] len_ext, inc;
   logic is_wrap, wrap_ok;
   assign len_ext = idx_width_p'(len_i);
   assign inc = idx_i + idx_width_p'(1);
   assign is_wrap = burst_i == e_axi_burst_wrap;
   assign wrap_ok = is_wrap && (len_i == len_width_p'(1) || len_i == len_width_p'(3)
                             || len_i == len_width_p'(7) || len_i == len_width_p'(15));
   assign illegal_o = burst_i == 2'b11 || (is_wrap && !wrap_ok);
   assign next_idx_o = burst_i == e_axi_burst_fixed ? idx_i
                     : wrap_ok ? (idx_i & ~len_ext) | (inc & len_ext)
                     : inc;
endmodule

// File: rtl/bsg_nonsynth_axi_burst_mem.sv
// bsg_nonsynth_axi_burst_mem: AXI4 slave memory model with FIXED/INCR/WRAP bursts, strobes, read latency.
module bsg_nonsynth_axi_burst_mem
   import bsg_axi_pkg::*;
#(
   parameter int axi_id_width_p   = 6,
   parameter int axi_addr_width_p = 32,
   parameter int axi_data_width_p = 64,
   parameter int axi_len_width_p  = 8,
   parameter int mem_els_p        = 1024,
   parameter logic [axi_data_width_p-1:0] init_data_p = '0,
   parameter int read_latency_p   = 0
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [axi_id_width_p-1:0]     axi_awid_i,
   input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
   input  logic [axi_len_width_p-1:0]    axi_awlen_i,
   input  logic [1:0]                    axi_awburst_i,
   input  logic                          axi_awvalid_i,
   output logic                          axi_awready_o,
   input  logic [axi_data_width_p-1:0]   axi_wdata_i,
   input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
   input  logic                          axi_wlast_i,
   input  logic                          axi_wvalid_i,
   output logic                          axi_wready_o,
   output logic [axi_id_width_p-1:0]     axi_bid_o,
   output logic [1:0]                    axi_bresp_o,
   output logic                          axi_bvalid_o,
   input  logic                          axi_bready_i,
   input  logic [axi_id_width_p-1:0]     axi_arid_i,
   input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
   input  logic [axi_len_width_p-1:0]    axi_arlen_i,
   input  logic [1:0]                    axi_arburst_i,
   input  logic                          axi_arvalid_i,
   output logic                          axi_arready_o,
   output logic [axi_id_width_p-1:0]     axi_rid_o,
   output logic [axi_data_width_p-1:0]   axi_rdata_o,
   output logic [1:0]                    axi_rresp_o,
   output logic                          axi_rlast_o,
   output logic                          axi_rvalid_o,
   input  logic                          axi_rready_i
);
   localparam int bytes_lp = axi_data_width_p / 8;
   localparam int lg_bytes_lp = $clog2(bytes_lp);
   localparam int idx_width_lp = axi_addr_width_p - lg_bytes_lp;
   localparam int mem_aw_lp = $clog2(mem_els_p);
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
   logic [axi_data_width_p-1:0] mem [mem_els_p];
   logic live_r;
   w_state_e w_state;
   r_state_e r_state;
   logic [axi_id_width_p-1:0] w_id, r_id;
   logic [idx_width_lp-1:0] w_idx, r_idx, w_next, r_next;
   logic [axi_len_width_p-1:0] w_len, r_len, w_cnt, r_cnt;
   logic [1:0] w_burst, r_burst;
   logic w_ill, r_ill, w_oor, r_oor, w_err, w_beat_err, w_last_beat;
   bsg_axi_resp_e w_resp;
   logic [31:0] wait_cnt;
   logic unused_addr_bits;
   assign unused_addr_bits = ^{axi_awaddr_i[lg_bytes_lp-1:0], axi_araddr_i[lg_bytes_lp-1:0]};
   bsg_axi_burst_addr_gen #(.idx_width_p(idx_width_lp), .len_width_p(axi_len_width_p)) w_gen (
      .idx_i(w_idx), .len_i(w_len), .burst_i(w_burst), .next_idx_o(w_next), .illegal_o(w_ill)
   );
   bsg_axi_burst_addr_gen #(.idx_width_p(idx_width_lp), .len_width_p(axi_len_width_p)) r_gen (
      .idx_i(r_idx), .len_i(r_len), .burst_i(r_burst), .next_idx_o(r_next), .illegal_o(r_ill)
   );
   assign axi_awready_o = live_r && w_state == W_IDLE;
   assign axi_wready_o = w_state == W_DATA;
   assign axi_bvalid_o = w_state == W_RESP;
   assign axi_bid_o = w_id;
   assign axi_bresp_o = w_resp;
   assign w_oor = w_idx >= idx_width_lp'(mem_els_p);
   assign w_last_beat = w_cnt == w_len;
   assign w_beat_err = w_err | w_ill | w_oor | (axi_wlast_i != w_last_beat);
   assign axi_arready_o = live_r && r_state == R_IDLE;
   assign axi_rvalid_o = r_state == R_DATA;
   assign axi_rid_o = r_id;
   assign r_oor = r_idx >= idx_width_lp'(mem_els_p);
   assign axi_rlast_o = axi_rvalid_o && r_cnt == r_len;
   assign axi_rdata_o = axi_rvalid_o && !r_oor ? mem[r_idx[mem_aw_lp-1:0]] : '0;
   assign axi_rresp_o = axi_rvalid_o ? axi_resp(r_oor | r_ill) : e_axi_resp_okay;
   always_ff @(posedge clk_i) live_r <= ~reset_i;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         w_state <= W_IDLE;
         w_id <= '0;
         w_idx <= '0;
         w_len <= '0;
         w_burst <= '0;
         w_cnt <= '0;
         w_err <= 1'b0;
         w_resp <= e_axi_resp_okay;
         for (int i = 0; i < mem_els_p; i++) mem[i] <= init_data_p;
      end else case (w_state)
         W_IDLE: if (axi_awvalid_i && axi_awready_o) begin
            w_id <= axi_awid_i;
            w_idx <= axi_awaddr_i[axi_addr_width_p-1:lg_bytes_lp];
            w_len <= axi_awlen_i;
            w_burst <= axi_awburst_i;
            w_cnt <= '0;
            w_err <= 1'b0;
            w_state <= W_DATA;
         end
         W_DATA: if (axi_wvalid_i) begin
            if (!w_oor)
               for (int b = 0; b < bytes_lp; b++)
                  if (axi_wstrb_i[b]) mem[w_idx[mem_aw_lp-1:0]][8*b+:8] <= axi_wdata_i[8*b+:8];
            w_idx <= w_next;
            w_cnt <= w_cnt + axi_len_width_p'(1);
            w_err <= w_beat_err;
            if (w_last_beat) begin
               w_resp <= axi_resp(w_beat_err);
               w_state <= W_RESP;
            end
         end
         W_RESP: if (axi_bready_i) w_state <= W_IDLE;
         default: w_state <= W_IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= R_IDLE;
         r_id <= '0;
         r_idx <= '0;
         r_len <= '0;
         r_burst <= '0;
         r_cnt <= '0;
         wait_cnt <= '0;
      end else case (r_state)
         R_IDLE: if (axi_arvalid_i && axi_arready_o) begin
            r_id <= axi_arid_i;
            r_idx <= axi_araddr_i[axi_addr_width_p-1:lg_bytes_lp];
            r_len <= axi_arlen_i;
            r_burst <= axi_arburst_i;
            r_cnt <= '0;
            wait_cnt <= 32'(read_latency_p - 1);
            r_state <= read_latency_p == 0 ? R_DATA : R_WAIT;
         end
         R_WAIT: begin
            wait_cnt <= wait_cnt - 32'd1;
            if (wait_cnt == 32'd0) r_state <= R_DATA;
         end
         R_DATA: if (axi_rready_i) begin
            if (axi_rlast_o) r_state <= R_IDLE;
            else begin
               r_cnt <= r_cnt + axi_len_width_p'(1);
               r_idx <= r_next;
            end
         end
         default: r_state <= R_IDLE;
      endcase
   end
endmodule

// File: tb/tb_bsg_nonsynth_axi_burst_mem.sv
// tb_bsg_nonsynth_axi_burst_mem: randomized bursts against an array model of the AXI burst memory.
module tb_bsg_nonsynth_axi_burst_mem;
   localparam int IW = 6, AW = 32, DW = 64, LW = 8, ELS = 64, LAT = 3;
   localparam logic [DW-1:0] INIT = 64'hDEAD_BEEF_0123_4567;
   logic clk = 0, reset = 0;
   logic [IW-1:0] awid = 0, arid = 0, bid, rid;
   logic [AW-1:0] awaddr = 0, araddr = 0;
   logic [LW-1:0] awlen = 0, arlen = 0;
   logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
   logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
   logic arvalid = 0, arready, rlast, rvalid, rready = 0;
   logic [DW-1:0] wdata = 0, rdata;
   logic [DW/8-1:0] wstrb = 0;
   int checks = 0, failures = 0;
   logic [DW-1:0] model [ELS];
   logic [DW-1:0] wd [256];
   logic [7:0] ws [256];
   always #5 clk = ~clk;
   bsg_nonsynth_axi_burst_mem #(
      .axi_id_width_p(IW), .axi_addr_width_p(AW), .axi_data_width_p(DW), .axi_len_width_p(LW),
      .mem_els_p(ELS), .init_data_p(INIT), .read_latency_p(LAT)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awburst_i(awburst),
      .axi_awvalid_i(awvalid), .axi_awready_o(awready),
      .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
      .axi_wready_o(wready),
      .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
      .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arburst_i(arburst),
      .axi_arvalid_i(arvalid), .axi_arready_o(arready),
      .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
      .axi_rvalid_o(rvalid), .axi_rready_i(rready)
   );
   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic bit legal_wrap(input int len);
      return len + 1 == 2 || len + 1 == 4 || len + 1 == 8 || len + 1 == 16;
   endfunction
   function automatic bit bad_burst(input int len, input int burst);
      return burst == 3 || (burst == 2 && !legal_wrap(len));
   endfunction
   function automatic int nxt(input int idx, input int len, input int burst);
      int n = len + 1;
      int base = idx - idx % n;
      if (burst == 0) return idx;
      if (burst == 2 && legal_wrap(len)) return base + (idx + 1 - base) % n;
      return idx + 1;
   endfunction
   task automatic axi_write(input int id, input int idx, input int len, input int burst, input bit early);
      int n, cur;
      bit err, lst;
      chk("wready_pre", wready, 0);
      awid = IW'(id); awaddr = AW'(idx * 8 + $urandom_range(0, 7)); awlen = LW'(len);
      awburst = 2'(burst); awvalid = 1;
      n = 0;
      while (!awready && n < 50) begin @(negedge clk); n++; end
      chk("aw_timeout", 64'(n < 50), 1);
      @(negedge clk);
      awvalid = 0;
      chk("wready_first", wready, 1);
      cur = idx;
      err = bad_burst(len, burst);
      for (int b = 0; b <= len; b++) begin
         lst = (b == len) ^ (early && b == 0);
         wdata = wd[b]; wstrb = ws[b]; wlast = lst; wvalid = 1;
         n = 0;
         while (!wready && n < 50) begin @(negedge clk); n++; end
         chk("w_timeout", 64'(n < 50), 1);
         if (cur < ELS) begin
            for (int k = 0; k < 8; k++) if (ws[b][k]) model[cur][8*k+:8] = wd[b][8*k+:8];
         end else err = 1;
         if (lst != (b == len)) err = 1;
         cur = nxt(cur, len, burst);
         @(negedge clk);
      end
      wvalid = 0; wlast = 0;
      n = 0;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      chk("b_timeout", 64'(n < 50), 1);
      chk("bid", bid, id);
      chk("bresp", bresp, err ? 2 : 0);
      bready = 1;
      @(negedge clk);
      bready = 0;
      chk("bvalid_clear", bvalid, 0);
      chk("awready_back", awready, 1);
   endtask
   task automatic axi_read(input int id, input int idx, input int len, input int burst);
      int n, cur, stall;
      bit ill;
      arid = IW'(id); araddr = AW'(idx * 8 + $urandom_range(0, 7)); arlen = LW'(len);
      arburst = 2'(burst); arvalid = 1;
      n = 0;
      while (!arready && n < 50) begin @(negedge clk); n++; end
      chk("ar_timeout", 64'(n < 50), 1);
      @(negedge clk);
      arvalid = 0;
      chk("arready_busy", arready, 0);
      n = 1;
      while (!rvalid && n < 20) begin @(negedge clk); n++; end
      chk("r_latency", n, 1 + LAT);
      cur = idx;
      ill = bad_burst(len, burst);
      for (int b = 0; b <= len; b++) begin
         stall = $urandom_range(0, 2);
         for (int s = 0; s <= stall; s++) begin
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, cur < ELS ? model[cur] : 0);
            chk("rresp", rresp, (ill || cur >= ELS) ? 2 : 0);
            chk("rlast", rlast, b == len);
            chk("rid", rid, id);
            if (s < stall) @(negedge clk);
         end
         rready = 1;
         @(negedge clk);
         rready = 0;
         cur = nxt(cur, len, burst);
      end
      chk("rvalid_end", rvalid, 0);
      chk("arready_end", arready, 1);
   endtask
   task automatic fill(input int len);
      for (int b = 0; b <= len; b++) begin
         wd[b] = {$urandom, $urandom};
         ws[b] = 8'($urandom);
      end
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end
   initial begin
      for (int i = 0; i < ELS; i++) model[i] = INIT;
      reset = 1;
      repeat (3) @(negedge clk);
      chk("rst_awready", awready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rlast", rlast, 0);
      reset = 0;
      @(negedge clk);
      chk("post_rst_awready", awready, 1);
      chk("post_rst_arready", arready, 1);
      axi_read(1, 5, 0, 1);
      wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
      for (int b = 0; b < 4; b++) ws[b] = 8'hFF;
      axi_write(3, 4, 3, 1, 0);
      axi_read(4, 4, 3, 1);
      axi_write(5, 6, 3, 1, 0);
      axi_read(6, 6, 3, 2);
      axi_read(7, 6, 2, 2);
      wd[0] = '1; ws[0] = 8'hFF;
      axi_write(8, 10, 0, 1, 0);
      wd[0] = '0; ws[0] = 8'h0F;
      axi_write(9, 10, 0, 1, 0);
      chk("strobe_model", model[10], 64'hFFFFFFFF_00000000);
      axi_read(10, 10, 0, 0);
      fill(1);
      axi_write(11, ELS, 1, 1, 0);
      axi_read(12, ELS, 1, 1);
      axi_read(13, 0, 0, 1);
      fill(1);
      axi_write(14, 20, 1, 1, 1);
      axi_read(15, 20, 1, 1);
      fill(255);
      axi_write(16, 0, 255, 1, 0);
      axi_read(17, 0, 255, 1);
      for (int t = 0; t < 24; t++) begin
         int idx = $urandom_range(0, ELS + 6);
         int len = $urandom_range(0, 15);
         int burst = $urandom_range(0, 3);
         fill(len);
         if ($urandom_range(0, 1) == 1) axi_write($urandom_range(0, 63), idx, len, burst, 0);
         else axi_read($urandom_range(0, 63), idx, len, burst);
      end
      fill(3);
      awid = 6'd2; awaddr = 32'h40; awlen = 8'd3; awburst = 2'b01; awvalid = 1;
      for (int n = 0; n < 50 && !awready; n++) @(negedge clk);
      @(negedge clk);
      awvalid = 0;
      for (int b = 0; b < 2; b++) begin
         wdata = wd[b]; wstrb = 8'hFF; wlast = 0; wvalid = 1;
         @(negedge clk);
      end
      wvalid = 0;
      reset = 1;
      @(negedge clk);
      chk("midrst_wready", wready, 0);
      chk("midrst_bvalid", bvalid, 0);
      chk("midrst_awready", awready, 0);
      reset = 0;
      for (int i = 0; i < ELS; i++) model[i] = INIT;
      @(negedge clk);
      chk("midrst_awready_back", awready, 1);
      axi_read(18, 8, 1, 1);
      axi_read(19, 4, 3, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
